// File: rtl/fft_r4_stream.sv
// rtl/fft_r4_stream.sv - streaming radix-4 DIT FFT built around one shared butterfly
module fft_r4_stream #(
  parameter int WIDTH    = 18,
  parameter int N        = 64,
  parameter int TW_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sample,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_index,
  output logic [WIDTH-1:0]     out_real,
  output logic [WIDTH-1:0]     out_imag,
  output logic [WIDTH:0]       out_mag,
  output logic                 out_last,
  output logic                 busy
);
  localparam int LOGN = $clog2(N);
  localparam int S    = LOGN / 2;
  localparam int BW   = LOGN - 2;
  localparam int SW   = $clog2(S);
  localparam int PW   = WIDTH + TW_WIDTH + 1;
  localparam int AW   = WIDTH + 3;
  localparam int TW_MAX = 2 ** (TW_WIDTH - 1) - 1;
  localparam real TW_SCALE = 2.0 ** (TW_WIDTH - 1);
  localparam real PI = 3.14159265358979323846;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW_WIDTH - 2);

  if (N < 16 || N > 1024 || (1 << LOGN) != N || (LOGN % 2) != 0) begin : g_bad_n
    $error("fft_r4_stream: N must be a power of 4 in 16..1024");
  end

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  state_t state, state_nx;

  logic [LOGN-1:0] cnt;
  logic [SW-1:0]   stage;
  logic [BW-1:0]   bfly;
  logic            last_bfly;

  logic signed [WIDTH-1:0]    mem_re [N];
  logic signed [WIDTH-1:0]    mem_im [N];
  logic signed [TW_WIDTH-1:0] tw_re  [N];
  logic signed [TW_WIDTH-1:0] tw_im  [N];

  // W_N^k = cos - j*sin, rounded to nearest; +1.0 clips to the largest positive code
  for (genvar k = 0; k < N; k++) begin : g_tw
    localparam int CR = int'($cos(2.0 * PI * k / N) * TW_SCALE);
    localparam int SR = int'(-$sin(2.0 * PI * k / N) * TW_SCALE);
    assign tw_re[k] = TW_WIDTH'((CR > TW_MAX) ? TW_MAX : CR);
    assign tw_im[k] = TW_WIDTH'((SR > TW_MAX) ? TW_MAX : SR);
  end

  function automatic logic [LOGN-1:0] digitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int d = 0; d < LOGN / 2; d++) r[2*d +: 2] = v[LOGN-2-2*d +: 2];
    return r;
  endfunction

  assign last_bfly = (stage == SW'(S - 1)) && (bfly == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LOGN'(N - 1)) state_nx = COMPUTE;
      end
      COMPUTE: if (last_bfly) state_nx = UNLOAD;
      UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && cnt == LOGN'(N - 1)) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // cnt is the sample number while loading and the bin number while unloading
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      stage <= '0;
      bfly  <= '0;
    end else begin
      if ((in_ready && in_valid) || (out_valid && out_ready)) cnt <= cnt + 1'b1;
      if (state == COMPUTE) begin
        bfly <= bfly + 1'b1;
        if (bfly == '1) stage <= (stage == SW'(S - 1)) ? '0 : stage + 1'b1;
      end
    end
  end

  int                     sh;
  logic [LOGN-1:0]        jj, base, step;
  logic [LOGN-1:0]        addr [4];
  logic [LOGN-1:0]        twk  [4];
  logic signed [PW-1:0]   pr   [4];
  logic signed [PW-1:0]   pim  [4];
  logic signed [WIDTH:0]  yr   [4];
  logic signed [WIDTH:0]  yi   [4];
  logic signed [AW-1:0]   er   [4];
  logic signed [AW-1:0]   ei   [4];
  logic signed [AW-1:0]   sr   [4];
  logic signed [AW-1:0]   si   [4];
  logic signed [WIDTH-1:0] zr  [4];
  logic signed [WIDTH-1:0] zi  [4];

  always_comb begin
    sh   = 2 * int'(stage);
    jj   = LOGN'(bfly) & LOGN'((1 << sh) - 1);
    base = ((LOGN'(bfly) >> sh) << (sh + 2)) | jj;
    step = jj << (LOGN - 2 - sh);
    for (int m = 0; m < 4; m++) begin
      addr[m] = base | LOGN'(m << sh);
      twk[m]  = LOGN'(m * int'(step));
      pr[m]   = '0;
      pim[m]  = '0;
      yr[m]   = (WIDTH+1)'(mem_re[addr[m]]);
      yi[m]   = (WIDTH+1)'(mem_im[addr[m]]);
      if (m != 0 && jj != '0) begin
        pr[m]  = PW'(mem_re[addr[m]]) * PW'(tw_re[twk[m]])
               - PW'(mem_im[addr[m]]) * PW'(tw_im[twk[m]]) + RND;
        pim[m] = PW'(mem_re[addr[m]]) * PW'(tw_im[twk[m]])
               + PW'(mem_im[addr[m]]) * PW'(tw_re[twk[m]]) + RND;
        yr[m]  = (WIDTH+1)'(pr[m] >>> (TW_WIDTH - 1));
        yi[m]  = (WIDTH+1)'(pim[m] >>> (TW_WIDTH - 1));
      end
      er[m] = AW'(yr[m]);
      ei[m] = AW'(yi[m]);
    end
    // X_q = sum_m y_m * (-j)^(q*m)
    sr[0] = er[0] + er[1] + er[2] + er[3];
    si[0] = ei[0] + ei[1] + ei[2] + ei[3];
    sr[1] = er[0] + ei[1] - er[2] - ei[3];
    si[1] = ei[0] - er[1] - ei[2] + er[3];
    sr[2] = er[0] - er[1] + er[2] - er[3];
    si[2] = ei[0] - ei[1] + ei[2] - ei[3];
    sr[3] = er[0] - ei[1] - er[2] + ei[3];
    si[3] = ei[0] + er[1] - ei[2] - er[3];
    for (int q = 0; q < 4; q++) begin
      zr[q] = WIDTH'(sr[q] >>> 2);
      zi[q] = WIDTH'(si[q] >>> 2);
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      mem_re[digitrev(cnt)] <= in_sample;
      mem_im[digitrev(cnt)] <= '0;
    end else if (state == COMPUTE) begin
      for (int q = 0; q < 4; q++) begin
        mem_re[addr[q]] <= zr[q];
        mem_im[addr[q]] <= zi[q];
      end
    end
  end

  logic signed [WIDTH:0] re_x, im_x;
  logic [WIDTH:0]        abs_re, abs_im, mag_max, mag_min;

  assign busy      = !in_ready;
  assign out_last  = out_valid && (cnt == LOGN'(N - 1));
  assign out_index = out_valid ? cnt : '0;
  assign out_real  = out_valid ? mem_re[cnt] : '0;
  assign out_imag  = out_valid ? mem_im[cnt] : '0;

  always_comb begin
    re_x    = (WIDTH+1)'(signed'(out_real));
    im_x    = (WIDTH+1)'(signed'(out_imag));
    abs_re  = re_x[WIDTH] ? -re_x : re_x;
    abs_im  = im_x[WIDTH] ? -im_x : im_x;
    mag_max = (abs_re > abs_im) ? abs_re : abs_im;
    mag_min = (abs_re > abs_im) ? abs_im : abs_re;
    out_mag = mag_max + (mag_min >> 1);
  end

endmodule

// File: tb/tb_fft_r4_stream.sv
// tb/tb_fft_r4_stream.sv - randomized bench for fft_r4_stream against a direct DFT model
module tb_fft_r4_stream;
  localparam int W = 18;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic sel64 = 1'b0;
  logic [W-1:0] in_sample = '0;

  logic in_ready16, out_valid16, last16, busy16;
  logic [3:0] idx16;
  logic [W-1:0] re16, im16;
  logic [W:0] mag16;
  logic in_ready64, out_valid64, last64, busy64;
  logic [5:0] idx64;
  logic [W-1:0] re64, im64;
  logic [W:0] mag64;

  fft_r4_stream #(.WIDTH(W), .N(16), .TW_WIDTH(18)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel64), .in_ready(in_ready16),
    .in_sample(in_sample), .out_valid(out_valid16), .out_ready(out_ready & ~sel64),
    .out_index(idx16), .out_real(re16), .out_imag(im16), .out_mag(mag16),
    .out_last(last16), .busy(busy16));

  fft_r4_stream #(.WIDTH(W), .N(64), .TW_WIDTH(18)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel64), .in_ready(in_ready64),
    .in_sample(in_sample), .out_valid(out_valid64), .out_ready(out_ready & sel64),
    .out_index(idx64), .out_real(re64), .out_imag(im64), .out_mag(mag64),
    .out_last(last64), .busy(busy64));

  logic m_in_ready, m_out_valid, m_last, m_busy;
  logic [5:0] m_idx;
  logic [W-1:0] m_re, m_im;
  logic [W:0] m_mag;
  assign m_in_ready  = sel64 ? in_ready64 : in_ready16;
  assign m_out_valid = sel64 ? out_valid64 : out_valid16;
  assign m_last      = sel64 ? last64 : last16;
  assign m_busy      = sel64 ? busy64 : busy16;
  assign m_idx       = sel64 ? idx64 : {2'b00, idx16};
  assign m_re        = sel64 ? re64 : re16;
  assign m_im        = sel64 ? im64 : im16;
  assign m_mag       = sel64 ? mag64 : mag16;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int x [64];
  int exp_re [64], exp_im [64], exp_mag [64];
  int got_re [64], got_im [64], ref_re [64], ref_im [64];

  task automatic check(input string tag, input longint obs, input longint expv, input longint tol = 0);
    longint d;
    d = obs - expv;
    if (d < 0) d = -d;
    n_checks++;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, expv, tol);
    end
  endtask

  // Direct DFT scaled by 1/N, rounded to nearest
  task automatic model(input int nn);
    real r, im, a;
    int ar, ai;
    for (int k = 0; k < nn; k++) begin
      r = 0.0;
      im = 0.0;
      for (int n = 0; n < nn; n++) begin
        a = 2.0 * PI * ((k * n) % nn) / nn;
        r = r + x[n] * $cos(a);
        im = im - x[n] * $sin(a);
      end
      exp_re[k] = int'(r / nn);
      exp_im[k] = int'(im / nn);
      ar = (exp_re[k] < 0) ? -exp_re[k] : exp_re[k];
      ai = (exp_im[k] < 0) ? -exp_im[k] : exp_im[k];
      exp_mag[k] = (ar > ai) ? ar + ai / 2 : ai + ar / 2;
    end
  endtask

  task automatic check_reset(input string tag);
    #1;
    check({tag, ":in_ready"}, m_in_ready, 1);
    check({tag, ":out_valid"}, m_out_valid, 0);
    check({tag, ":busy"}, m_busy, 0);
    check({tag, ":out_last"}, m_last, 0);
    check({tag, ":out_index"}, m_idx, 0);
    check({tag, ":out_real"}, m_re, 0);
    check({tag, ":out_imag"}, m_im, 0);
    check({tag, ":out_mag"}, m_mag, 0);
  endtask

  task automatic run_frame(input string tag, input int nn, input bit thr, input int max_bins,
                           input int stop_after, input int tol);
    int n, k, cyc, acc_cyc, first_cyc, st, sb, mtol;
    n = 0; k = 0; cyc = 0; acc_cyc = -1; first_cyc = -1;
    st = 0;
    for (int t = 1; t < nn; t = t * 4) st++;
    sb = st * nn / 4;
    mtol = (tol == 0) ? 0 : tol + tol / 2 + 1;
    while (k < max_bins && cyc < 4000 &&
           !(stop_after > 0 && n == nn && cyc - acc_cyc == stop_after)) begin
      in_valid  = thr ? ($urandom_range(0, 3) != 0) : (n < nn);
      in_sample = (n < nn) ? W'(x[n]) : W'($urandom);
      out_ready = thr ? ($urandom_range(0, 9) < 3) : 1'b1;
      #1;
      check({tag, ":in_ready"}, m_in_ready, n < nn);
      check({tag, ":busy"}, m_busy, n == nn);
      check({tag, ":out_valid"}, m_out_valid, n == nn && cyc - acc_cyc > sb);
      if (m_out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        check({tag, ":index"}, m_idx, k);
        check({tag, ":last"}, m_last, k == nn - 1);
        check({tag, ":real"}, int'($signed(m_re)), exp_re[k], tol);
        check({tag, ":imag"}, int'($signed(m_im)), exp_im[k], tol);
        check({tag, ":mag"}, m_mag, exp_mag[k], mtol);
        if (out_ready) begin
          got_re[k] = int'($signed(m_re));
          got_im[k] = int'($signed(m_im));
          k++;
        end
      end
      if (in_valid && m_in_ready && n < nn) begin
        n++;
        if (n == nn) acc_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (stop_after == 0) begin
      check({tag, ":bins_done"}, k, max_bins);
      check({tag, ":latency"}, first_cyc - acc_cyc, sb + 1);
    end else begin
      check({tag, ":stop_point"}, cyc - acc_cyc, stop_after);
    end
  endtask

  task automatic load_impulse();
    for (int n = 0; n < 64; n++) x[n] = (n == 0) ? 4096 : 0;
  endtask

  initial begin
    int nn, tol;
    repeat (2) @(negedge clk);
    sel64 = 1'b0;
    check_reset("reset16");
    sel64 = 1'b1;
    check_reset("reset64");
    rst_n = 1'b1;
    sel64 = 1'b0;
    @(negedge clk);

    load_impulse();
    model(16);
    run_frame("impulse16", 16, 1'b0, 16, 0, 0);

    for (int n = 0; n < 16; n++) x[n] = (n % 2 == 1) ? -1600 : 1600;
    model(16);
    run_frame("nyquist16", 16, 1'b0, 16, 0, 2);

    sel64 = 1'b1;
    for (int n = 0; n < 64; n++) x[n] = 1000;
    model(64);
    run_frame("dc64", 64, 1'b0, 64, 0, 3);

    for (int n = 0; n < 64; n++) x[n] = int'(8000.0 * $cos(2.0 * PI * ((5 * n) % 64) / 64.0));
    model(64);
    run_frame("cosine64", 64, 1'b0, 64, 0, 6);

    for (int pass = 0; pass < 2; pass++) begin
      nn = (pass == 0) ? 16 : 64;
      tol = (pass == 0) ? 4 : 5;
      sel64 = (nn == 64);
      for (int n = 0; n < 64; n++) x[n] = int'($urandom_range(0, 40000)) - 20000;
      model(nn);
      run_frame("random", nn, 1'b0, nn, 0, tol);
      for (int k = 0; k < nn; k++) begin
        ref_re[k] = got_re[k];
        ref_im[k] = got_im[k];
      end
      for (int f = 0; f < 3; f++) begin
        run_frame("throttled", nn, 1'b1, nn, 0, tol);
        for (int k = 0; k < nn; k++) begin
          check("throttled:exact_re", got_re[k], ref_re[k]);
          check("throttled:exact_im", got_im[k], ref_im[k]);
        end
      end
    end

    sel64 = 1'b0;
    load_impulse();
    model(16);
    run_frame("abort_compute", 16, 1'b0, 16, 6, 0);
    rst_n = 1'b0;
    check_reset("reset_compute");
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("after_reset1", 16, 1'b0, 16, 0, 0);

    run_frame("abort_unload", 16, 1'b0, 8, 0, 0);
    rst_n = 1'b0;
    check_reset("reset_unload");
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("after_reset2", 16, 1'b0, 16, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
